systolic_tile_feeder: RTL and testbench

//  Transmit side of the systolic array's row/col/instruction streams.

---
 rtl/systolic_pkg.sv | 35 +++
 rtl/tile_ram.sv | 26 ++
 rtl/systolic_tile_feeder.sv | 199 +++++++++++++++++++
 tb/tb_systolic_tile_feeder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile feeder and the array-side instruction decoder.
// Holds FSM encodings, CSR offsets and instruction/config field positions.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSTR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CSR_CTRL       = 8'h00;
    localparam logic [7:0] CSR_CONFIG     = 8'h04;
    localparam logic [7:0] CSR_ROWS_SENT  = 8'h08;
    localparam logic [7:0] CSR_COLS_SENT  = 8'h0C;
    localparam logic [7:0] CSR_TILES_DONE = 8'h10;
    localparam logic [7:0] CSR_REJECTED   = 8'h14;
    localparam logic [31:0] CSR_UNMAPPED  = 32'hDEAD_BEEF;

    // Instruction word layout; the array top decodes the same positions.
    localparam int DIM_W           = 12;
    localparam int INSTR_NCOLS_LSB = 0;
    localparam int INSTR_NROWS_LSB = 12;

    localparam int CFG_NROWS_LSB = 0;
    localparam int CFG_NCOLS_LSB = 16;

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] v, input int depth);
        if (v == '0 || int'(v) > depth) begin
            return DIM_W'(depth);
        end
        return v;
    endfunction

endpackage

// File: rtl/tile_ram.sv
// One-write / one-read synchronous RAM holding a single DEPTH x DATA_WIDTH tile.
// The read port registers every cycle so the output follows the address one cycle later.
module tile_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage and read register carry no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/systolic_tile_feeder.sv
// Transmit side of the systolic array: holds one row tile and one col tile, then on start
// issues an instruction beat followed by both tiles streamed at one beat per cycle per side.
module systolic_tile_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int CSR_AW     = 8
) (
    input  logic                  clock_sink,
    input  logic                  reset_sink_reset_n,
    input  logic [CSR_AW-1:0]     csr_address,
    input  logic                  csr_write,
    input  logic [31:0]           csr_writedata,
    input  logic                  csr_read,
    output logic [31:0]           csr_readdata,
    input  logic                  ld_write,
    input  logic                  ld_sel,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [31:0]           st_instr_data,
    output logic                  st_instr_valid,
    input  logic                  st_instr_ready,
    output logic [DATA_WIDTH-1:0] st_rows_data,
    output logic                  st_rows_valid,
    input  logic                  st_rows_ready,
    output logic [DATA_WIDTH-1:0] st_cols_data,
    output logic                  st_cols_valid,
    input  logic                  st_cols_ready,
    output logic                  done_irq
);

    localparam int PTR_W = ADDR_W + 1;

    state_t state, state_nxt;

    logic [PTR_W-1:0] rp, cp, rp_nxt, cp_nxt;
    logic [PTR_W-1:0] rows_lim, cols_lim;
    logic [DIM_W-1:0] n_rows, n_cols;
    logic [31:0]      rows_sent, cols_sent, tiles_done, rejected_loads;
    logic [31:0]      csr_rd_mux;
    logic             rows_acc, cols_acc;
    logic             start_req, cfg_req, load_ok;
    logic             row_we, col_we;
    logic             unused_cfg_bits;

    assign start_req = csr_write && (csr_address == CSR_CTRL) && csr_writedata[0];
    assign cfg_req   = csr_write && (csr_address == CSR_CONFIG);
    assign unused_cfg_bits = ^{csr_writedata[31:28], csr_writedata[15:12]};

    // Loads land only while idle; a load and a start in the same cycle still write first.
    assign load_ok = ld_write && (state == IDLE);
    assign row_we  = load_ok && !ld_sel;
    assign col_we  = load_ok && ld_sel;

    // Configured sizes never exceed DEPTH, so the low pointer-width bits are the full count.
    assign rows_lim = n_rows[PTR_W-1:0];
    assign cols_lim = n_cols[PTR_W-1:0];

    assign st_rows_valid = (state == STREAM) && (rp < rows_lim);
    assign st_cols_valid = (state == STREAM) && (cp < cols_lim);
    assign rows_acc      = st_rows_valid && st_rows_ready;
    assign cols_acc      = st_cols_valid && st_cols_ready;

    // Reading ptr+accept lets the RAM register refresh on the same edge that consumes a beat.
    assign rp_nxt = rp + PTR_W'(rows_acc);
    assign cp_nxt = cp + PTR_W'(cols_acc);

    always_ff @(posedge clock_sink) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_sink_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        state_nxt      = state;
        st_instr_valid = 1'b0;
        done_irq       = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_nxt = INSTR;
                end
            end
            INSTR: begin
                st_instr_valid = 1'b1;
                if (st_instr_ready) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (rp_nxt == rows_lim && cp_nxt == cols_lim) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_irq  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        st_instr_data = '0;
        st_instr_data[INSTR_NROWS_LSB +: DIM_W] = n_rows;
        st_instr_data[INSTR_NCOLS_LSB +: DIM_W] = n_cols;
    end

    always_ff @(posedge clock_sink) begin
        if (!reset_sink_reset_n) begin
            rp             <= '0;
            cp             <= '0;
            n_rows         <= DIM_W'(DEPTH);
            n_cols         <= DIM_W'(DEPTH);
            rows_sent      <= '0;
            cols_sent      <= '0;
            tiles_done     <= '0;
            rejected_loads <= '0;
        end else begin
            if (state == STREAM) begin
                rp <= rp_nxt;
                cp <= cp_nxt;
            end else begin
                rp <= '0;
                cp <= '0;
            end
            rows_sent <= rows_sent + 32'(rows_acc);
            cols_sent <= cols_sent + 32'(cols_acc);
            if (state == DONE) begin
                tiles_done <= tiles_done + 32'd1;
            end
            if (ld_write && state != IDLE) begin
                rejected_loads <= rejected_loads + 32'd1;
            end
            if (cfg_req && state == IDLE) begin
                n_rows <= clamp_dim(csr_writedata[CFG_NROWS_LSB +: DIM_W], DEPTH);
                n_cols <= clamp_dim(csr_writedata[CFG_NCOLS_LSB +: DIM_W], DEPTH);
            end
        end
    end

    always_comb begin
        csr_rd_mux = CSR_UNMAPPED;
        case (csr_address)
            CSR_CTRL:       csr_rd_mux = {30'b0, state};
            CSR_CONFIG: begin
                csr_rd_mux = '0;
                csr_rd_mux[CFG_NROWS_LSB +: DIM_W] = n_rows;
                csr_rd_mux[CFG_NCOLS_LSB +: DIM_W] = n_cols;
            end
            CSR_ROWS_SENT:  csr_rd_mux = rows_sent;
            CSR_COLS_SENT:  csr_rd_mux = cols_sent;
            CSR_TILES_DONE: csr_rd_mux = tiles_done;
            CSR_REJECTED:   csr_rd_mux = rejected_loads;
            default:        csr_rd_mux = CSR_UNMAPPED;
        endcase
    end

    always_ff @(posedge clock_sink) begin
        if (!reset_sink_reset_n) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            csr_readdata <= csr_rd_mux;
        end
    end

    tile_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_row_ram (
        .clk   (clock_sink),
        .we    (row_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (rp_nxt[ADDR_W-1:0]),
        .rdata (st_rows_data)
    );

    tile_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_col_ram (
        .clk   (clock_sink),
        .we    (col_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (cp_nxt[ADDR_W-1:0]),
        .rdata (st_cols_data)
    );

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Scoreboard bench for systolic_tile_feeder: stimulus queues expected beats and CSR values,
// a negedge monitor pops and compares them whenever the DUT hands something over.
module tb_systolic_tile_feeder;

    logic         clock_sink;
    logic         reset_sink_reset_n;
    logic [7:0]   csr_address;
    logic         csr_write;
    logic [31:0]  csr_writedata;
    logic         csr_read;
    logic [31:0]  csr_readdata;
    logic         ld_write;
    logic         ld_sel;
    logic [3:0]   ld_addr;
    logic [127:0] ld_data;
    logic [31:0]  st_instr_data;
    logic         st_instr_valid;
    logic         st_instr_ready;
    logic [127:0] st_rows_data;
    logic         st_rows_valid;
    logic         st_rows_ready;
    logic [127:0] st_cols_data;
    logic         st_cols_valid;
    logic         st_cols_ready;
    logic         done_irq;

    systolic_tile_feeder dut (
        .clock_sink         (clock_sink),
        .reset_sink_reset_n (reset_sink_reset_n),
        .csr_address        (csr_address),
        .csr_write          (csr_write),
        .csr_writedata      (csr_writedata),
        .csr_read           (csr_read),
        .csr_readdata       (csr_readdata),
        .ld_write           (ld_write),
        .ld_sel             (ld_sel),
        .ld_addr            (ld_addr),
        .ld_data            (ld_data),
        .st_instr_data      (st_instr_data),
        .st_instr_valid     (st_instr_valid),
        .st_instr_ready     (st_instr_ready),
        .st_rows_data       (st_rows_data),
        .st_rows_valid      (st_rows_valid),
        .st_rows_ready      (st_rows_ready),
        .st_cols_data       (st_cols_data),
        .st_cols_valid      (st_cols_valid),
        .st_cols_ready      (st_cols_ready),
        .done_irq           (done_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] mdl_rows [16];
    logic [127:0] mdl_cols [16];

    logic [31:0]  exp_instr [$];
    logic [127:0] exp_rows  [$];
    logic [127:0] exp_cols  [$];
    logic [31:0]  exp_csr   [$];
    logic [7:0]   exp_csr_addr [$];

    int irq_exp = 0;
    int irq_seen = 0;
    int mon_instr_cnt = 0, mon_rows_cnt = 0, mon_cols_cnt = 0;
    int mon_instr_cyc = 0, mon_rows_last = 0, mon_cols_last = 0, mon_last_acc = 0;

    logic rows_rand = 1'b0, cols_rand = 1'b0;
    logic rows_rdy = 1'b1, cols_rdy = 1'b1;

    initial begin
        clock_sink = 1'b0;
        forever #5 clock_sink = ~clock_sink;
    end

    initial forever begin
        @(posedge clock_sink);
        cyc++;
    end

    initial begin
        st_rows_ready = 1'b0;
        st_cols_ready = 1'b0;
        forever begin
            @(posedge clock_sink);
            #2;
            st_rows_ready = rows_rand ? 1'($urandom_range(0, 1)) : rows_rdy;
            st_cols_ready = cols_rand ? 1'($urandom_range(0, 1)) : cols_rdy;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s_extra: got an unexpected handshake, expected none", name);
    endtask

    // Monitor: compares every accepted beat, every read response and every done pulse.
    initial begin
        logic csr_chk = 1'b0;
        logic rows_stall = 1'b0;
        logic cols_stall = 1'b0;
        forever begin
            @(negedge clock_sink);
            if (csr_chk) begin
                if (exp_csr.size() == 0) extra("csr");
                else check($sformatf("csr_rd_%02h", exp_csr_addr.pop_front()), csr_readdata, exp_csr.pop_front());
            end
            csr_chk = csr_read;
            if (rows_stall) check("rows_valid_hold", st_rows_valid, 1);
            if (cols_stall) check("cols_valid_hold", st_cols_valid, 1);
            rows_stall = st_rows_valid && !st_rows_ready && reset_sink_reset_n;
            cols_stall = st_cols_valid && !st_cols_ready && reset_sink_reset_n;
            if (st_instr_valid === 1'b1 && st_instr_ready) begin
                if (exp_instr.size() == 0) extra("instr");
                else check("instr_beat", st_instr_data, exp_instr.pop_front());
                mon_instr_cnt++;
                mon_instr_cyc = cyc;
            end
            if (st_rows_valid === 1'b1 && st_rows_ready) begin
                if (exp_rows.size() == 0) extra("rows");
                else check($sformatf("rows_beat_%0d", 16 - exp_rows.size()), st_rows_data, exp_rows.pop_front());
                mon_rows_cnt++;
                mon_rows_last = cyc;
                mon_last_acc = cyc;
            end
            if (st_cols_valid === 1'b1 && st_cols_ready) begin
                if (exp_cols.size() == 0) extra("cols");
                else check($sformatf("cols_beat_%0d", 16 - exp_cols.size()), st_cols_data, exp_cols.pop_front());
                mon_cols_cnt++;
                mon_cols_last = cyc;
                mon_last_acc = cyc;
            end
            if (done_irq === 1'b1) begin
                irq_seen++;
                check("done_irq_latency", 128'(cyc - mon_last_acc), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clock_sink);
        #1;
    endtask

    task automatic csr_wr(input logic [7:0] addr, input logic [31:0] data);
        csr_write = 1'b1;
        csr_address = addr;
        csr_writedata = data;
        tick();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] addr, input logic [31:0] exp);
        csr_read = 1'b1;
        csr_address = addr;
        exp_csr.push_back(exp);
        exp_csr_addr.push_back(addr);
        tick();
        csr_read = 1'b0;
    endtask

    task automatic ld(input logic sel, input logic [3:0] addr, input logic [127:0] data);
        ld_write = 1'b1;
        ld_sel = sel;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_write = 1'b0;
    endtask

    task automatic push_run(input logic [11:0] nr, input logic [11:0] nc);
        exp_instr.push_back({8'h00, nr, nc});
        for (int i = 0; i < int'(nr); i++) exp_rows.push_back(mdl_rows[i]);
        for (int i = 0; i < int'(nc); i++) exp_cols.push_back(mdl_cols[i]);
        irq_exp++;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_instr.size() != 0 || exp_rows.size() != 0 || exp_cols.size() != 0 ||
                irq_seen != irq_exp) && n < 1000) begin
            tick();
            n++;
        end
        check({name, "_completes"}, n < 1000, 1);
        tick();
    endtask

    task automatic reset_dut();
        reset_sink_reset_n = 1'b0;
        repeat (2) tick();
        reset_sink_reset_n = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        reset_sink_reset_n = 1'b0;
        csr_address = '0;
        csr_write = 1'b0;
        csr_writedata = '0;
        csr_read = 1'b0;
        ld_write = 1'b0;
        ld_sel = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        st_instr_ready = 1'b1;
        tick();
        reset_dut();

        check("reset_rows_valid", st_rows_valid, 0);
        check("reset_cols_valid", st_cols_valid, 0);
        check("reset_instr_valid", st_instr_valid, 0);
        check("reset_done_irq", done_irq, 0);
        check("reset_readdata", csr_readdata, 0);
        csr_rd(8'h00, 32'h0000_0000);
        csr_rd(8'h04, 32'h0010_0010);
        csr_rd(8'h08, 32'h0000_0000);

        // Test 1: full tiles, ready always high, contiguous streaming.
        for (int k = 0; k < 16; k++) begin
            mdl_rows[k] = {16{8'(k)}};
            mdl_cols[k] = {16{8'(8'h10 + k)}};
            ld(1'b0, 4'(k), mdl_rows[k]);
            ld(1'b1, 4'(k), mdl_cols[k]);
        end
        push_run(12'd16, 12'd16);
        csr_wr(8'h00, 32'h1);
        wait_done("t1");
        check("t1_rows_span", 128'(mon_rows_last - mon_instr_cyc), 16);
        check("t1_cols_span", 128'(mon_cols_last - mon_instr_cyc), 16);
        csr_rd(8'h10, 32'd1);

        // Test 2: held instruction, then independent random back-pressure.
        reset_dut();
        st_instr_ready = 1'b0;
        rows_rand = 1'b1;
        cols_rand = 1'b1;
        push_run(12'd16, 12'd16);
        csr_wr(8'h00, 32'h1);
        repeat (3) tick();
        check("t2_instr_valid_held", st_instr_valid, 1);
        check("t2_instr_data_held", st_instr_data, 32'h0001_0010);
        st_instr_ready = 1'b1;
        wait_done("t2");
        rows_rand = 1'b0;
        cols_rand = 1'b0;
        csr_rd(8'h08, 32'd16);
        csr_rd(8'h0C, 32'd16);
        csr_rd(8'h10, 32'd1);

        // Test 3: reduced and clamped sizes.
        csr_wr(8'h04, 32'h0004_0004);
        csr_rd(8'h04, 32'h0004_0004);
        push_run(12'd4, 12'd4);
        csr_wr(8'h00, 32'h1);
        wait_done("t3a");
        csr_rd(8'h08, 32'd20);
        csr_wr(8'h04, 32'h0011_0003);
        csr_rd(8'h04, 32'h0010_0003);
        push_run(12'd3, 12'd16);
        csr_wr(8'h00, 32'h1);
        wait_done("t3b");
        csr_rd(8'h08, 32'd23);
        csr_rd(8'h0C, 32'd36);
        csr_wr(8'h04, 32'h0000_0000);
        csr_rd(8'h04, 32'h0010_0010);

        // Test 4: loads and start while streaming are dropped.
        rows_rdy = 1'b0;
        cols_rdy = 1'b0;
        push_run(12'd16, 12'd16);
        base = mon_instr_cnt;
        csr_wr(8'h00, 32'h1);
        n = 0;
        while (mon_instr_cnt == base && n < 50) begin
            tick();
            n++;
        end
        check("t4_instr_accepted", 128'(mon_instr_cnt - base), 1);
        ld(1'b0, 4'd2, {128{1'b1}});
        ld(1'b1, 4'd5, {128{1'b1}});
        csr_wr(8'h00, 32'h1);
        csr_rd(8'h00, 32'd2);
        csr_rd(8'h14, 32'd2);
        rows_rdy = 1'b1;
        cols_rdy = 1'b1;
        wait_done("t4");
        csr_rd(8'h10, 32'd4);
        csr_rd(8'h08, 32'd39);
        csr_rd(8'h0C, 32'd52);
        csr_rd(8'h00, 32'd0);

        // Test 5: reset at row beat 7, then a clean replay.
        push_run(12'd16, 12'd16);
        base = mon_rows_cnt;
        csr_wr(8'h00, 32'h1);
        n = 0;
        while (mon_rows_cnt - base < 7 && n < 200) begin
            tick();
            n++;
        end
        check("t5_rows_before_reset", 128'(mon_rows_cnt - base), 7);
        rows_rdy = 1'b0;
        cols_rdy = 1'b0;
        reset_sink_reset_n = 1'b0;
        tick();
        check("t5_rows_valid_reset", st_rows_valid, 0);
        check("t5_cols_valid_reset", st_cols_valid, 0);
        check("t5_done_irq_reset", done_irq, 0);
        reset_sink_reset_n = 1'b1;
        exp_rows.delete();
        exp_cols.delete();
        irq_exp--;
        csr_rd(8'h00, 32'd0);
        csr_rd(8'h08, 32'd0);
        check("t5_no_irq_after_reset", 128'(irq_seen), 128'(irq_exp));
        rows_rdy = 1'b1;
        cols_rdy = 1'b1;
        push_run(12'd16, 12'd16);
        csr_wr(8'h00, 32'h1);
        wait_done("t5");
        csr_rd(8'h08, 32'd16);
        csr_rd(8'h10, 32'd1);

        // Load and start in one cycle: the start sees the freshly written col beat.
        csr_wr(8'h04, 32'h0001_0001);
        mdl_cols[0] = 128'hA5A5_5A5A_0123_4567_89AB_CDEF_F0E1_D2C3;
        push_run(12'd1, 12'd1);
        ld_write = 1'b1;
        ld_sel = 1'b1;
        ld_addr = 4'd0;
        ld_data = mdl_cols[0];
        csr_write = 1'b1;
        csr_address = 8'h00;
        csr_writedata = 32'h1;
        tick();
        ld_write = 1'b0;
        csr_write = 1'b0;
        wait_done("t5b");
        csr_rd(8'h08, 32'd17);
        csr_rd(8'h14, 32'd0);

        // Test 6: unmapped address.
        csr_rd(8'h3C, 32'hDEAD_BEEF);
        repeat (3) tick();
        check("csr_queue_drained", 128'(exp_csr.size()), 0);
        check("irq_total", 128'(irq_seen), 128'(irq_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
